// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared encodings, FSM states and the operand shifter
package alu_sequencer_pkg;

   localparam int W    = 16;
   localparam int NREG = 8;

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;

   localparam logic [1:0] SH_LSL = 2'b01;
   localparam logic [1:0] SH_LSR = 2'b10;
   localparam logic [1:0] SH_ASR = 2'b11;

   localparam logic [1:0] ALU_ADD = 2'b00;

   typedef enum logic [2:0] {
      S_WAIT      = 3'd0,
      S_DECODE    = 3'd1,
      S_WRITE_IMM = 3'd2,
      S_GET_A     = 3'd3,
      S_GET_B     = 3'd4,
      S_EXEC      = 3'd5,
      S_WRITE_C   = 3'd6
   } state_t;

   // One-bit shift of operand B; code 00 passes the value through unchanged
   function automatic logic [W-1:0] shift(input logic [W-1:0] v, input logic [1:0] sh);
      return sh == SH_LSL ? {v[W-2:0], 1'b0} :
             sh == SH_LSR ? {1'b0, v[W-1:1]} :
             sh == SH_ASR ? {v[W-1], v[W-1:1]} : v;
   endfunction

endpackage

// File: rtl/alu_sequencer_regfile8x16.sv
// regfile8x16: 8x16 register file, one synchronous write port, two asynchronous read ports
import alu_sequencer_pkg::*;

module regfile8x16 (
   input  logic         clk,
   input  logic         reset,
   input  logic         we,
   input  logic [2:0]   wa,
   input  logic [W-1:0] wd,
   input  logic [2:0]   ra1,
   input  logic [2:0]   ra2,
   output logic [W-1:0] rd1,
   output logic [W-1:0] rd2
);

   logic [W-1:0] r [NREG];

   assign rd1 = r[ra1];
   assign rd2 = r[ra2];

   // Clear every register on reset, otherwise write the addressed one when enabled
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) r[i] <= '0;
      end else if (we) begin
         r[wa] <= wd;
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: decodes one instruction, stages operands to the external ALU and writes back
import alu_sequencer_pkg::*;

module alu_sequencer (
   input  logic         clk,
   input  logic         reset,
   input  logic         s,
   input  logic [15:0]  in,
   output logic         w,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [1:0]   alu_op,
   input  logic [W-1:0] alu_c,
   input  logic         alu_z,
   output logic         status,
   output logic [W-1:0] datapath_out
);

   state_t       state, next;
   logic [15:0]  ir;
   logic [W-1:0] a, b, c, rd1, rd2;

   wire [2:0] opc  = ir[15:13];
   wire [1:0] op   = ir[12:11];
   wire [2:0] rn   = ir[10:8];
   wire [2:0] rd   = ir[7:5];
   wire [1:0] sh   = ir[4:3];
   wire [2:0] rm   = ir[2:0];
   wire [7:0] imm8 = ir[7:0];

   wire mov_imm = opc == OPC_MOV && op == OP_MOV_IMM;
   wire mov_reg = opc == OPC_MOV && op == OP_MOV_REG;
   wire alu_ins = opc == OPC_ALU;
   wire is_cmp  = alu_ins && op == OP_CMP;

   wire write_imm = state == S_WRITE_IMM;

   // Immediate writes target Rn; ALU results held in C target Rd
   regfile8x16 u_rf (
      .clk   (clk),
      .reset (reset),
      .we    (write_imm || state == S_WRITE_C),
      .wa    (write_imm ? rn : rd),
      .wd    (write_imm ? {{8{imm8[7]}}, imm8} : c),
      .ra1   (rn),
      .ra2   (rm),
      .rd1   (rd1),
      .rd2   (rd2)
   );

   assign alu_a        = mov_reg ? '0 : a;
   assign alu_b        = shift(b, sh);
   assign alu_op       = mov_reg ? ALU_ADD : op;
   assign datapath_out = c;

   // State register; reset abandons any in-flight instruction
   always_ff @(posedge clk) begin
      if (reset) state <= S_WAIT;
      else       state <= next;
   end

   // Next-state and handshake output
   always_comb begin
      next = state;
      w    = state == S_WAIT;
      case (state)
         S_WAIT:      next = s ? S_DECODE : S_WAIT;
         S_DECODE:    next = mov_imm ? S_WRITE_IMM : (mov_reg || alu_ins) ? S_GET_A : S_WAIT;
         S_GET_A:     next = S_GET_B;
         S_GET_B:     next = S_EXEC;
         S_EXEC:      next = is_cmp ? S_WAIT : S_WRITE_C;
         default:     next = S_WAIT;
      endcase
   end

   // Instruction latch, operand staging and result/flag capture
   always_ff @(posedge clk) begin
      if (reset) begin
         ir     <= '0;
         a      <= '0;
         b      <= '0;
         c      <= '0;
         status <= 1'b0;
      end else begin
         if (state == S_WAIT && s) ir <= in;
         if (state == S_GET_A) a <= rd1;
         if (state == S_GET_B) b <= rd2;
         if (state == S_EXEC) c <= alu_c;
         if (state == S_EXEC && is_cmp) status <= alu_z;
      end
   end

endmodule
